mux4_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the 4-to-1 multiplexer datapath in the ALU. Four requesters each present a data word and a request. The block grants one requester at a time, drives the mux select, and registers the selected data onto a shared output. Each requester's tenure is capped at MAX_HOLD cycles so that no source can starve the others.

---
 rtl/mux4_rr_arbiter.sv | 159 +++++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// Purpose: round-robin arbiter and sequencer for a 4-to-1 mux, with registered select/data/grant.
// Latency: 1 edge from req to gnt/valid/o; 1 edge from req[s] falling to release.
// Backpressure: none downstream; tenure capped at MAX_HOLD cycles, hand-over without bubble.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   req[3:0]        per-requester request, req[i] pairs with Ii
//   I0..I3 [W-1:0]  requester data
//   gnt[3:0]        registered one-hot grant, zero when idle
//   s[1:0]          registered mux select (current or last grant)
//   o[W-1:0]        registered selected data
//   valid           o carries data from a granted requester
module mux4_rr_arbiter #(
  parameter int W        = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   req,
  input  logic [W-1:0] I0,
  input  logic [W-1:0] I1,
  input  logic [W-1:0] I2,
  input  logic [W-1:0] I3,
  output logic [3:0]   gnt,
  output logic [1:0]   s,
  output logic [W-1:0] o,
  output logic         valid
);

  localparam int            CW      = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_HOLD);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    ptr_q,   ptr_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [3:0]    gnt_q,   gnt_d;
  logic [1:0]    s_q,     s_d;
  logic [W-1:0]  o_q,     o_d;
  logic          valid_q, valid_d;

  logic [W-1:0]  din [4];

  assign din[0] = I0;
  assign din[1] = I1;
  assign din[2] = I2;
  assign din[3] = I3;

  // Release happens when the owner drops its request or has used its full tenure.
  logic       release_c;
  logic [1:0] base_c;

  always_comb begin
    release_c = !req[s_q] || (cnt_q == CNT_MAX);
    // While granted, the search is only consumed on release, where the
    // pointer has just moved past the owner; so search from s+1 directly.
    base_c    = (state_q == ST_GRANT) ? (s_q + 2'd1) : ptr_q;
  end

  // Winner search: scan base, base+1, base+2, base+3 (mod 4). The loop runs
  // from the farthest offset down so the nearest requester is written last.
  logic       win_vld;
  logic [1:0] win_idx;
  logic [1:0] probe;

  always_comb begin
    win_vld = 1'b0;
    win_idx = 2'd0;
    probe   = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      probe = base_c + 2'(k);
      if (req[probe]) begin
        win_vld = 1'b1;
        win_idx = probe;
      end
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    s_d     = s_q;
    o_d     = o_q;
    valid_d = valid_q;

    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          state_d = ST_GRANT;
          gnt_d   = 4'b0001 << win_idx;
          s_d     = win_idx;
          cnt_d   = CNT_ONE;
          o_d     = din[win_idx];
          valid_d = 1'b1;
        end
      end

      ST_GRANT: begin
        if (!release_c) begin
          cnt_d = cnt_q + CNT_ONE;
          o_d   = din[s_q];
        end else begin
          ptr_d = s_q + 2'd1;
          if (win_vld) begin
            // Hand over (possibly back to the same sole requester) with no bubble.
            gnt_d = 4'b0001 << win_idx;
            s_d   = win_idx;
            cnt_d = CNT_ONE;
            o_d   = din[win_idx];
          end else begin
            // s and o keep their last values; only grant and valid drop.
            state_d = ST_IDLE;
            gnt_d   = 4'b0000;
            valid_d = 1'b0;
            cnt_d   = '0;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= 2'd0;
      cnt_q   <= '0;
      gnt_q   <= 4'b0000;
      s_q     <= 2'd0;
      o_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      s_q     <= s_d;
      o_q     <= o_d;
      valid_q <= valid_d;
    end
  end

  assign gnt   = gnt_q;
  assign s     = s_q;
  assign o     = o_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
module tb_mux4_rr_arbiter;

  localparam int W    = 4;
  localparam int NDUT = 3;
  localparam int MHS [NDUT] = '{8, 2, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [3:0]   req;
  logic [W-1:0] i0, i1, i2, i3;

  logic [3:0]   gnt_a   [NDUT];
  logic [1:0]   s_a     [NDUT];
  logic [W-1:0] o_a     [NDUT];
  logic         valid_a [NDUT];

  mux4_rr_arbiter #(.W(W), .MAX_HOLD(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .I0(i0), .I1(i1), .I2(i2), .I3(i3),
    .gnt(gnt_a[0]), .s(s_a[0]), .o(o_a[0]), .valid(valid_a[0])
  );

  mux4_rr_arbiter #(.W(W), .MAX_HOLD(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .I0(i0), .I1(i1), .I2(i2), .I3(i3),
    .gnt(gnt_a[1]), .s(s_a[1]), .o(o_a[1]), .valid(valid_a[1])
  );

  mux4_rr_arbiter #(.W(W), .MAX_HOLD(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .I0(i0), .I1(i1), .I2(i2), .I3(i3),
    .gnt(gnt_a[2]), .s(s_a[2]), .o(o_a[2]), .valid(valid_a[2])
  );

  // Expected output record, pushed when stimulus is driven, popped after the edge.
  typedef struct {
    int           id;
    logic [3:0]   gnt;
    logic [1:0]   s;
    logic [W-1:0] o;
    logic         valid;
  } exp_t;

  // Hand-written vector: inputs for one cycle and outputs of the MAX_HOLD=8 unit after the edge.
  // d packs {I3, I2, I1, I0}.
  typedef struct {
    logic [3:0]     req;
    logic [4*W-1:0] d;
    logic [3:0]     gnt;
    logic [1:0]     s;
    logic [W-1:0]   o;
    logic           valid;
  } vec_t;

  exp_t sb[$];
  vec_t tv [14];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic cmp(input string name, input int id, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s dut%0d at %0t: got %0h, expected %0h", name, id, $time, act, want);
    end
  endtask

  task automatic check_exp(input exp_t e);
    cmp("gnt",   e.id, 32'(gnt_a[e.id]),   32'(e.gnt));
    cmp("s",     e.id, 32'(s_a[e.id]),     32'(e.s));
    cmp("valid", e.id, 32'(valid_a[e.id]), 32'(e.valid));
    if (e.valid) cmp("o", e.id, 32'(o_a[e.id]), 32'(e.o));
  endtask

  task automatic check_reset_state(input string tag);
    for (int id = 0; id < NDUT; id++) begin
      cmp({tag, "_gnt"},   id, 32'(gnt_a[id]),   32'h0);
      cmp({tag, "_s"},     id, 32'(s_a[id]),     32'h0);
      cmp({tag, "_o"},     id, 32'(o_a[id]),     32'h0);
      cmp({tag, "_valid"}, id, 32'(valid_a[id]), 32'h0);
    end
  endtask

  task automatic step_begin(input logic [3:0] r, input logic [4*W-1:0] d);
    @(negedge clk);
    req = r;
    {i3, i2, i1, i0} = d;
  endtask

  task automatic step_end();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_exp(e);
    end
  endtask

  // Assert reset between edges; outputs must clear before any edge arrives.
  task automatic reset_pulse(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_state(tag);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b0000;
  endtask

  // Fixed request set held from an idle start with ptr = 0 (or a single requester):
  // the owner cycles through the active indices in ascending order, MAX_HOLD cycles each.
  task automatic run_rotation(input logic [3:0] r, input int ncyc);
    int             act[$];
    int             w;
    logic [4*W-1:0] d;
    exp_t           e;
    for (int i = 0; i < 4; i++) if (r[i]) act.push_back(i);
    for (int k = 0; k < ncyc; k++) begin
      d = (4*W)'($urandom);
      step_begin(r, d);
      for (int id = 0; id < NDUT; id++) begin
        w       = act[(k / MHS[id]) % act.size()];
        e.id    = id;
        e.gnt   = 4'b0001 << w;
        e.s     = w[1:0];
        e.o     = d[w*W +: W];
        e.valid = 1'b1;
        sb.push_back(e);
      end
      step_end();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;

    //        req      {I3,I2,I1,I0}  gnt      s     o     valid
    tv = '{
      '{4'b0100, 16'h0100, 4'b0100, 2'd2, 4'h1, 1'b1},  // single requester 2
      '{4'b0100, 16'h0100, 4'b0100, 2'd2, 4'h1, 1'b1},
      '{4'b0100, 16'h0100, 4'b0100, 2'd2, 4'h1, 1'b1},
      '{4'b0000, 16'h0000, 4'b0000, 2'd2, 4'h1, 1'b0},  // release edge -> idle, s holds
      '{4'b0000, 16'h0000, 4'b0000, 2'd2, 4'h1, 1'b0},
      '{4'b1000, 16'h0000, 4'b1000, 2'd3, 4'h0, 1'b1},  // grant 3 with I3 = 0
      '{4'b1000, 16'h1000, 4'b1000, 2'd3, 4'h1, 1'b1},  // I3 -> 1 shows up on o
      '{4'b1001, 16'h0005, 4'b1000, 2'd3, 4'h0, 1'b1},  // req0 waits behind owner
      '{4'b0001, 16'h1005, 4'b0001, 2'd0, 4'h5, 1'b1},  // req3 drops -> 0, no bubble
      '{4'b0001, 16'h0006, 4'b0001, 2'd0, 4'h6, 1'b1},
      '{4'b0000, 16'h0000, 4'b0000, 2'd0, 4'h6, 1'b0},  // idle, ptr now 1
      '{4'b0011, 16'h0093, 4'b0010, 2'd1, 4'h9, 1'b1},  // ptr=1: requester 1 beats 0
      '{4'b0001, 16'h0093, 4'b0001, 2'd0, 4'h3, 1'b1},  // hand-over 1 -> 0
      '{4'b0000, 16'h0000, 4'b0000, 2'd0, 4'h3, 1'b0}
    };

    rst_n = 1'b0;
    req   = 4'b0000;
    {i3, i2, i1, i0} = '0;
    repeat (2) @(negedge clk);
    check_reset_state("por");
    rst_n = 1'b1;

    // Table-driven directed vectors against the MAX_HOLD=8 unit
    for (int i = 0; i < 14; i++) begin
      step_begin(tv[i].req, tv[i].d);
      e.id    = 0;
      e.gnt   = tv[i].gnt;
      e.s     = tv[i].s;
      e.o     = tv[i].o;
      e.valid = tv[i].valid;
      sb.push_back(e);
      step_end();
    end

    // Hold req = 0100 for 3 cycles, then reset mid-grant
    run_rotation(4'b0100, 3);
    reset_pulse("rst_mid");

    // Full load: 8/2/1-cycle tenures rotating 0,1,2,3,0,...
    run_rotation(4'b1111, 40);
    reset_pulse("rst_b");

    // Sparse contention between requesters 1 and 3
    run_rotation(4'b1010, 12);
    reset_pulse("rst_c");

    // Sole requester held past several tenure boundaries
    run_rotation(4'b0010, 20);

    cmp("sb_empty", 0, 32'(sb.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
